// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: shares one byte-wide RAM port between i-cache refills and
// MEM-stage loads/stores. Each granted access is broken into per-byte RAM
// cycles; 32-bit words are assembled or split little-endian, and the winner
// gets a one-cycle completion pulse.
module mem_arbiter_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [WORD_W-1:0] inst_data,
  output logic              inst_valid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_len,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  output logic [WORD_W-1:0] data_rdata,
  output logic              data_valid,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic {SRC_INST, SRC_DATA} src_e;

  state_e            state_q, state_d;
  src_e              last_grant_q, last_grant_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [2:0]        step_q, step_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [WORD_W-1:0] inst_data_q, inst_data_d;
  logic [WORD_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_valid_q, inst_valid_d;
  logic              data_valid_q, data_valid_d;

  logic       grant_any;
  logic       grant_data;
  logic       go_write;
  logic [2:0] grant_len;
  logic       read_last;
  logic       write_last;
  logic [1:0] cap_sel;
  logic [1:0] wr_sel;

  // Grant decision: round-robin on contention, otherwise whoever is asking
  always_comb begin
    grant_any  = inst_req | data_req;
    grant_data = data_req & (~inst_req | (last_grant_q == SRC_INST));
    go_write   = grant_data & data_we;
    grant_len  = 3'd4;
    if (grant_data) begin
      case (data_len)
        2'b00:   grant_len = 3'd1;
        2'b01:   grant_len = 3'd2;
        default: grant_len = 3'd4;
      endcase
    end
    read_last  = (step_q == len_q + 3'd1);
    write_last = (issue_cnt_q == len_q);
    cap_sel    = 2'(step_q - 3'd2);
    wr_sel     = issue_cnt_q[1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: reads finish one edge after the last byte is issued, writes on it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = go_write ? WRITE : READ;
      READ:    if (read_last) state_d = DONE;
      WRITE:   if (write_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/outputs: latch the grant, walk byte addresses, assemble or split words
  always_comb begin
    last_grant_d = last_grant_q;
    src_d        = src_q;
    base_d       = base_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    issue_cnt_d  = issue_cnt_q;
    step_d       = step_q;
    asm_d        = asm_q;
    ram_a_d      = ram_a_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          src_d       = grant_data ? SRC_DATA : SRC_INST;
          base_d      = grant_data ? data_addr : inst_addr;
          len_d       = grant_len;
          wdata_d     = data_wdata;
          ram_a_d     = grant_data ? data_addr : inst_addr;
          issue_cnt_d = 3'd1;
          step_d      = 3'd1;
          asm_d       = '0;
          if (inst_req && data_req) last_grant_d = grant_data ? SRC_DATA : SRC_INST;
          if (go_write) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = data_wdata[7:0];
          end
        end
      end
      READ: begin
        step_d = step_q + 3'd1;
        if (issue_cnt_q < len_q) begin
          ram_a_d     = base_q + ADDR_W'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        if (step_q >= 3'd2) asm_d[{cap_sel, 3'b000} +: 8] = ram_din;
        if (read_last) begin
          ram_a_d = '0;
          if (src_q == SRC_INST) begin
            inst_data_d  = asm_d;
            inst_valid_d = 1'b1;
          end else begin
            data_rdata_d = asm_d;
            data_valid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (write_last) begin
          ram_wr_d     = 1'b0;
          ram_a_d      = '0;
          data_valid_d = 1'b1;
        end else begin
          ram_a_d     = base_q + ADDR_W'(issue_cnt_q);
          ram_dout_d  = wdata_q[{wr_sel, 3'b000} +: 8];
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset aborts any transfer and parks the RAM port
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_INST;
      src_q        <= SRC_INST;
      base_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      issue_cnt_q  <= '0;
      step_q       <= '0;
      asm_q        <= '0;
      ram_a_q      <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= 1'b0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      base_q       <= base_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      issue_cnt_q  <= issue_cnt_d;
      step_q       <= step_d;
      asm_q        <= asm_d;
      ram_a_q      <= ram_a_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign inst_data  = inst_data_q;
  assign inst_valid = inst_valid_q;
  assign data_rdata = data_rdata_q;
  assign data_valid = data_valid_q;
  assign ram_dout   = ram_dout_q;
  assign ram_a      = ram_a_q;
  assign ram_wr     = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: drives the arbiter against a byte RAM model and checks
// bus traces, assembled data, latencies and arbitration order.
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [1:0]  data_len = 2'b00;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int errors = 0;
  int checks = 0;

  // 64 KiB RAM mirrored over the address space, plus the bench's own reference copy
  logic [7:0] ram_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    bit          is_inst;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  mem_arbiter_ctrl #(.ADDR_W(32), .WORD_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data), .inst_valid(inst_valid),
    .data_req(data_req), .data_we(data_we), .data_len(data_len), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on ram_wr, read data appears the cycle after the address
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a[15:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[15:0]];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int lenBytes(input logic [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input int nbytes);
    logic [31:0] w;
    logic [31:0] a;
    w = '0;
    for (int k = 0; k < nbytes; k++) begin
      a = addr + 32'(k);
      w[8*k +: 8] = ref_mem[a[15:0]];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pokeBoth(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a[15:0]] = b;
    ref_mem[a[15:0]] = b;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transfer, started at a negedge with the DUT idle; trace-checked per byte
  task automatic applyStimulus(input bit is_inst, input bit we, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_word, input int exp_lat);
    int   nbytes;
    bit   is_write;
    bit   got;
    int   n;
    logic v;
    logic [31:0] a;
    nbytes   = is_inst ? 4 : lenBytes(len);
    is_write = !is_inst && we;
    if (is_inst) begin
      inst_req  = 1'b1;
      inst_addr = addr;
    end else begin
      data_req   = 1'b1;
      data_we    = we;
      data_len   = len;
      data_addr  = addr;
      data_wdata = wdata;
    end
    n   = 0;
    got = 0;
    @(posedge clk);
    @(negedge clk);
    while (!got && n <= 12) begin
      if (n < nbytes) begin
        checkOutput("trace_ram_a", ram_a, addr + 32'(n));
        checkOutput("trace_ram_wr", 32'(ram_wr), 32'(is_write));
        if (is_write) checkOutput("trace_ram_dout", 32'(ram_dout), 32'(wdata[8*n +: 8]));
      end
      v = is_inst ? inst_valid : data_valid;
      if (v) begin
        got = 1;
        checkOutput("latency", 32'(n), 32'(exp_lat));
        checkOutput("done_ram_wr", 32'(ram_wr), 32'd0);
        checkOutput("done_ram_a", ram_a, 32'd0);
        checkOutput("other_valid", 32'(is_inst ? data_valid : inst_valid), 32'd0);
        if (is_inst) checkOutput("inst_data", inst_data, exp_word);
        else if (!is_write) checkOutput("data_rdata", data_rdata, exp_word);
      end else begin
        n++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: got no valid, expected one after %0d cycles", exp_lat);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("valid_cleared", 32'({inst_valid, data_valid}), 32'd0);
    if (is_write) begin
      for (int k = 0; k < nbytes; k++) begin
        a = addr + 32'(k);
        ref_mem[a[15:0]] = wdata[8*k +: 8];
      end
    end
  endtask

  // Counts edges until the chosen valid is seen; an expired bound is a failure
  task automatic waitValid(input bit want_inst, input int limit, output int edges);
    bit found;
    edges = 0;
    found = 0;
    while (!found && edges < limit) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (want_inst ? inst_valid : data_valid) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout: got no %s valid within %0d cycles", want_inst ? "inst" : "data", limit);
    end
  endtask

  initial begin
    int e;
    bit r_inst;
    bit r_we;
    logic [1:0] r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    int r_n;

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    pokeBoth(32'h100, 8'h13);
    pokeBoth(32'h101, 8'h05);
    pokeBoth(32'h102, 8'h50);
    pokeBoth(32'h103, 8'h00);
    pokeBoth(32'h2001, 8'hF7);
    pokeBoth(32'hFFFFFFFE, 8'h11);
    pokeBoth(32'hFFFFFFFF, 8'h22);
    pokeBoth(32'h00000000, 8'h33);
    pokeBoth(32'h00000001, 8'h44);

    vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h00000100, 32'h0,        32'h00500513, 5};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h00002001, 32'h0,        32'h000000F7, 2};
    vecs[2]  = '{1'b0, 1'b1, 2'b10, 32'h00003000, 32'hDEADBEEF, 32'h0,        4};
    vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'h00003000, 32'h0,        32'hDEADBEEF, 5};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'h00003002, 32'h0,        32'h0000DEAD, 3};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 32'h00003000, 32'h0,        32'hDEADBEEF, 5};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 32'h00003001, 32'h12345677, 32'h0,        1};
    vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h00003000, 32'h0,        32'hDEAD77EF, 5};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h44332211, 5};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000A5C3, 32'h0,        2};
    vecs[10] = '{1'b0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h44A5C311, 5};

    applyReset();
    checkOutput("reset_ram_a", ram_a, 32'd0);
    checkOutput("reset_ram_dout", 32'(ram_dout), 32'd0);
    checkOutput("reset_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("reset_inst_data", inst_data, 32'd0);
    checkOutput("reset_data_rdata", data_rdata, 32'd0);
    checkOutput("reset_valids", 32'({inst_valid, data_valid}), 32'd0);

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].is_inst, vecs[i].we, vecs[i].len, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_word, vecs[i].exp_lat);

    // Contention: after reset data wins first, then the held inst request follows
    applyReset();
    inst_req  = 1'b1;
    inst_addr = 32'h100;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_len  = 2'b00;
    data_addr = 32'h2001;
    waitValid(1'b0, 20, e);
    checkOutput("cont1_data_lat", 32'(e), 32'd3);
    checkOutput("cont1_inst_quiet", 32'(inst_valid), 32'd0);
    checkOutput("cont1_rdata", data_rdata, 32'h000000F7);
    data_req = 1'b0;
    waitValid(1'b1, 20, e);
    checkOutput("cont1_inst_lat", 32'(e), 32'd7);
    checkOutput("cont1_inst_data", inst_data, 32'h00500513);
    inst_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inst_req = 1'b1;
    data_req = 1'b1;
    waitValid(1'b1, 20, e);
    checkOutput("cont2_inst_lat", 32'(e), 32'd6);
    checkOutput("cont2_data_quiet", 32'(data_valid), 32'd0);
    inst_req = 1'b0;
    waitValid(1'b0, 20, e);
    checkOutput("cont2_data_lat", 32'(e), 32'd4);
    checkOutput("cont2_rdata", data_rdata, 32'h000000F7);
    data_req = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset lands on the edge after the second store byte is presented
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_len   = 2'b10;
    data_addr  = 32'h5000;
    data_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstw_b0_wr", 32'(ram_wr), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstw_b1_a", ram_a, 32'h5001);
    rst      = 1'b1;
    data_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstw_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("rstw_ram_a", ram_a, 32'd0);
    checkOutput("rstw_valid", 32'(data_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstw_valid_after", 32'(data_valid), 32'd0);
    ref_mem[16'h5000] = 8'h0D;
    ref_mem[16'h5001] = 8'hF0;
    applyStimulus(1'b0, 1'b0, 2'b10, 32'h5000, 32'h0, modelRead(32'h5000, 4), 5);

    // Randomised traffic checked against the reference memory
    for (int t = 0; t < 60; t++) begin
      r_inst  = ($urandom_range(0, 2) == 0);
      r_we    = 1'($urandom_range(0, 1));
      r_len   = 2'($urandom_range(0, 3));
      r_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) r_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                           r_addr = 32'h4000 + 32'($urandom_range(0, 15));
      r_n = r_inst ? 4 : lenBytes(r_len);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (!r_inst && r_we)
        applyStimulus(r_inst, r_we, r_len, r_addr, r_wdata, 32'h0, r_n);
      else
        applyStimulus(r_inst, r_we, r_len, r_addr, r_wdata, modelRead(r_addr, r_n), r_n + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Arbitrates the single byte-wide RAM port between i-cache refill requests and data (load/store) requests from the MEM stage.
- Sequences each grant into per-byte RAM cycles and assembles or splits 32-bit words, little-endian.
- Returns one-cycle completion pulses to the winning requester.
- Sits between i_cache / MEM stage and external RAM.

Parameters:
- ADDR_W, 32, address width of requester and RAM addresses.
- WORD_W, 32, instruction/data word width (4 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  i-cache miss refill request; held until inst_valid
- inst_addr  in  ADDR_W  refill address; stable while inst_req is high
- inst_data  out  WORD_W  fetched instruction word
- inst_valid  out  1  one-cycle pulse; inst_data is valid
- data_req  in  1  data access request; held until data_valid
- data_we  in  1  1 = store, 0 = load
- data_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = treated as 4 bytes
- data_addr  in  ADDR_W  byte address
- data_wdata  in  WORD_W  store data; low bytes used
- data_rdata  out  WORD_W  load data, zero-extended
- data_valid  out  1  one-cycle pulse; load data valid or store complete
- ram_din  in  8  RAM read byte; valid the cycle after address is presented
- ram_dout  out  8  RAM write byte
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write, 0 = read

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ram_a = 0; ram_dout = 0; ram_wr = 0; inst_data = 0; data_rdata = 0; inst_valid = 0; data_valid = 0; last_grant = INST.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE grant rules:
  - Only data_req high: grant data.
  - Only inst_req high: grant inst.
  - Both high: grant the requester opposite last_grant (round-robin); update last_grant.
  - Instruction grants always read 4 bytes.
  - Data grant with data_we = 1 goes to WRITE; otherwise READ.
- Grant edge E0 (all cases):
  - Latch base address, len (in bytes), source and wdata.
  - ram_a <= base; byte counter issue_cnt <= 1.
- READ:
  - Issuing: at each edge while issue_cnt < len, ram_a <= base + issue_cnt and issue_cnt increments. ram_wr stays 0.
  - Capture: byte k is sampled from ram_din at edge E(k+2) into bits [8k+7:8k] of the assembly register.
  - Completion: at E(len+1), the last byte is captured, the assembled word is written to inst_data or data_rdata, the matching valid is set to 1, state goes to DONE, and ram_a returns to 0.
  - Latency: valid is high in the cycle after E(len+1); 5 cycles after the grant edge for 4 bytes, 2 cycles for 1 byte.
- WRITE:
  - At E0: ram_wr <= 1 and ram_dout <= wdata[7:0].
  - At E(k), k = 1..len-1: ram_a <= base + k and ram_dout <= byte k.
  - At E(len): ram_wr <= 0, ram_a <= 0, data_valid <= 1, state goes to DONE.
- DONE:
  - Valid is high for exactly this one cycle.
  - Requests are ignored in DONE (so the requester can drop req); next edge goes to IDLE and valid clears.
  - Back-to-back accesses therefore have a one-cycle IDLE bubble minimum.
- Address arithmetic is modulo 2^ADDR_W; base + k wraps from 0xFFFFFFFF to 0.
- Unused upper bytes of data_rdata are 0; byte count is the unsigned len value.
- The non-granted requester waits with its request held; it is granted in the next IDLE.
- Request dropped mid-transfer: protocol violation; the transfer still completes and valid still pulses.
- Reset mid-operation: at the reset edge, abort the transfer, force ram_wr = 0, produce no valid pulse, return to IDLE.

Test Plan:
- Inst fetch: RAM[0x100..0x103] = 13,05,50,00; inst_req at 0x100 -> ram_a = 0x100..0x103 on consecutive cycles, ram_wr = 0 throughout, inst_data = 0x00500513, inst_valid pulses 1 cycle, 5 cycles after grant.
- Byte load: data_len = 00, addr 0x2001, RAM[0x2001] = 0xF7 -> data_rdata = 0x000000F7, data_valid 2 cycles after grant, exactly 1 RAM read issued.
- Word store: data_we = 1, len = 10, addr 0x3000, wdata = 0xDEADBEEF -> ram_wr high 4 cycles with (0x3000, EF), (0x3001, BE), (0x3002, AD), (0x3003, DE); data_valid next edge; ram_wr = 0 after.
- Contention: inst_req and data_req rise together with last_grant = INST -> data served first, then inst granted after DONE → IDLE; next simultaneous pair serves inst first.
- Wrap: 4-byte load at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset during WRITE after the 2nd byte -> ram_wr = 0 next cycle, no data_valid, state IDLE, new request accepted normally.
